mips_debug_loader: RTL and testbench
====================================

// Module: mips_debug_loader
// PURPOSE
// Hardware counterpart of the bench-side program load and register check. Takes a
// byte stream from the UART RX, writes instruction words into the IF-stage instruction
// memory, and releases the MIPS core to run. When the core raises halt, it streams
// registers $0..$31 back out through a UART TX byte handshake.
// PARAMETERS
// IMEM_ADDR_W     8        instruction memory word-address width
// RUN_TIMEOUT     100000   max run cycles before forced stop (> 0)
// PORTS
// clk            in   1    clock
// reset          in   1    synchronous, active-low
// i_rx_data      in   8    received byte
// i_rx_valid     in   1    one-cycle strobe, i_rx_data valid
// o_tx_data      out  8    byte to transmit
// o_tx_valid     out  1    o_tx_data valid
// i_tx_ready     in   1    TX accepts byte when valid&&ready
// o_imem_we      out  1    instruction memory write enable (1-cycle pulse)
// o_imem_addr    out  IMEM_ADDR_W  word address
// o_imem_wdata   out  32   instruction word
// o_cpu_reset    out  1    active-high hold of MIPS core
// i_cpu_halt     in   1    core halt flag
// o_reg_addr     out  5    register bank read address
// i_reg_rdata    in   32   register bank read data (combinational)
// o_busy         out  1    high in every state except IDLE
// BEHAVIOUR
// Reset (reset==0 at posedge): state=IDLE, o_cpu_reset=1, o_imem_we=0, o_imem_addr=0,
//   o_imem_wdata=0, o_tx_valid=0, o_tx_data=0, o_reg_addr=0, o_busy=0; in-flight ops aborted.
// States: IDLE, LOAD_CNT, LOAD_DATA, RUN, DUMP_RD, DUMP_TX.
// IDLE: rx 0x4C 'L' -> LOAD_CNT; rx 0x52 'R' -> RUN; other bytes ignored.
// LOAD_CNT: next rx byte N = word count. N==0 -> IDLE, no writes. Else word/byte ctrs=0,
//   o_imem_addr=0 -> LOAD_DATA.
// LOAD_DATA: bytes assembled big-endian (first byte = bits 31:24). On 4th byte:
//   o_imem_wdata=word and o_imem_we=1 on the following cycle, for exactly one cycle.
//   o_imem_addr increments after each write, wrapping mod 2^IMEM_ADDR_W.
//   After N words -> IDLE. Core stays held (o_cpu_reset=1) throughout.
// RUN: o_cpu_reset=0 from the cycle after entry; run counter counts cycles.
//   i_cpu_halt==1 -> o_cpu_reset=1, -> DUMP_RD with reg idx 0.
//   Counter reaches RUN_TIMEOUT without halt -> o_cpu_reset=1; first transmit 0xEE, then dump.
//   halt and timeout on the same cycle: halt wins, no 0xEE.
// DUMP_RD: o_reg_addr=idx; i_reg_rdata is captured into the 32-bit shift reg
//   one cycle later -> DUMP_TX.
// DUMP_TX: 4 bytes per register, MSB first. o_tx_valid held high and o_tx_data stable
//   until i_tx_ready. After the 4th accepted byte: idx<31 -> idx+1, DUMP_RD;
//   idx==31 -> IDLE, o_tx_valid=0.
// RX bytes arriving in RUN/DUMP_RD/DUMP_TX are dropped, with no queueing.
// i_rx_valid in the same cycle as a state exit is handled by the old state only.
// Widths: word ctr 9 bits (N up to 255). Run counter sized $clog2(RUN_TIMEOUT+1), saturating.
// Dump length fixed at 128 bytes (129 with timeout marker).
// TESTING
// 1) 'L',N=2,bytes 20 01 00 05 20 02 00 64 -> we pulses @addr0=0x20010005, @addr1=0x20020064;
//    back in IDLE, o_cpu_reset still 1.
// 2) 'R', model halts after 20 cycles, regs $1=5,$2=100 -> o_cpu_reset 0 for 20 cycles then 1;
//    TX = 00000000 00000005 00000064 ..., 128 bytes total.
// 3) TX backpressure: i_tx_ready low 5 cycles mid-word -> o_tx_data/o_tx_valid stable;
//    no byte lost or duplicated.
// 4) RUN_TIMEOUT=50, halt never asserted -> first TX byte 0xEE, then 128 dump bytes,
//    o_cpu_reset=1 at cycle 50.
// 5) IMEM_ADDR_W=2, N=5 -> writes to addrs 0,1,2,3,0 (wrap); 'L',N=0 -> no writes.
// 6) reset low mid-LOAD_DATA and mid-DUMP_TX -> all outputs at reset values next cycle;
//    new 'L' works; junk bytes 0x00/0xFF in IDLE ignored.

Source files
------------

// File: rtl/mips_debug_loader_if.sv
// UART byte link between the debug loader and its host.
//   i_rx_data / i_rx_valid : received byte plus one-cycle strobe
//   o_tx_data / o_tx_valid : byte offered to the transmitter
//   i_tx_ready             : transmitter accepts the byte when valid && ready
// Handshakes: RX is a bare strobe with no back-pressure; a byte is taken in the
// cycle i_rx_valid is high or lost. TX is valid/ready: once o_tx_valid rises,
// o_tx_valid and o_tx_data hold unchanged until the clock edge at which
// i_tx_ready is also high, which is the single cycle the byte transfers.
// master: the UART side (drives RX, consumes TX); slave: the loader.
interface mips_debug_loader_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;

    modport master (
        output i_rx_data, i_rx_valid, i_tx_ready,
        input  o_tx_data, o_tx_valid
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_ready,
        output o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/mips_debug_loader.sv
// Debug loader for the MIPS core. Receives a program over the UART byte link,
// writes it into instruction memory, releases the core to run, and after halt
// (or a run timeout) streams registers $0..$31 back, four bytes each, MSB first.
// Host commands: 'L' N w0b3 w0b2 w0b1 w0b0 ... loads N big-endian words from
// address 0; 'R' runs the core.
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   uart            byte link (slave modport), see mips_debug_loader_if
//   o_imem_we/addr/wdata  instruction memory write port, one-cycle pulses
//   o_cpu_reset     active-high hold of the core (high everywhere but RUN)
//   i_cpu_halt      core halt flag, looked at only in RUN
//   o_reg_addr / i_reg_rdata  register bank read port, combinational read
//   o_busy          high whenever the loader is not idle
//   o_dbg_state     current FSM state encoding
module mips_debug_loader #(
    parameter int IMEM_ADDR_W = 8,
    parameter int RUN_TIMEOUT = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_debug_loader_if.slave     uart,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [31:0]            o_imem_wdata,
    output logic                   o_cpu_reset,
    input  logic                   i_cpu_halt,
    output logic [4:0]             o_reg_addr,
    input  logic [31:0]            i_reg_rdata,
    output logic                   o_busy,
    output logic [2:0]             o_dbg_state
);

    localparam int RUN_CNT_W = $clog2(RUN_TIMEOUT + 1);
    localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [RUN_CNT_W-1:0] RUN_MAX  = RUN_CNT_W'(RUN_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_CNT  = 3'd1,
        S_LOAD_DATA = 3'd2,
        S_RUN       = 3'd3,
        S_DUMP_RD   = 3'd4,
        S_DUMP_TX   = 3'd5
    } state_t;

    state_t               state, state_nxt;
    logic [7:0]           word_total;
    logic [8:0]           word_ctr;
    logic [1:0]           byte_ctr;
    logic [23:0]          asm_q;
    logic [RUN_CNT_W-1:0] run_cnt;
    logic [31:0]          shreg;
    logic [4:0]           reg_idx;
    logic [1:0]           tx_cnt;
    logic                 marker;

    logic load_byte, load_last_byte, last_word;
    logic run_halt, run_timeout, tx_fire;

    assign load_byte      = (state == S_LOAD_DATA) && uart.i_rx_valid;
    assign load_last_byte = load_byte && (byte_ctr == 2'd3);
    assign last_word      = (word_ctr + 9'd1) == {1'b0, word_total};
    // Halt has priority over a timeout landing in the same cycle.
    assign run_halt       = (state == S_RUN) && i_cpu_halt;
    assign run_timeout    = (state == S_RUN) && !i_cpu_halt && (run_cnt == RUN_LAST);
    assign tx_fire        = (state == S_DUMP_TX) && uart.i_tx_ready;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (uart.i_rx_valid) begin
                    if (uart.i_rx_data == 8'h4C)      state_nxt = S_LOAD_CNT;
                    else if (uart.i_rx_data == 8'h52) state_nxt = S_RUN;
                end
            end
            S_LOAD_CNT: begin
                if (uart.i_rx_valid)
                    state_nxt = (uart.i_rx_data == 8'h00) ? S_IDLE : S_LOAD_DATA;
            end
            S_LOAD_DATA: begin
                if (load_last_byte && last_word) state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (run_halt)         state_nxt = S_DUMP_RD;
                else if (run_timeout) state_nxt = S_DUMP_TX;  // 0xEE marker first
            end
            S_DUMP_RD: state_nxt = S_DUMP_TX;
            S_DUMP_TX: begin
                if (tx_fire) begin
                    if (marker)                state_nxt = S_DUMP_RD;
                    else if (tx_cnt == 2'd3)   state_nxt = (reg_idx == 5'd31) ? S_IDLE : S_DUMP_RD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            word_total   <= '0;
            word_ctr     <= '0;
            byte_ctr     <= '0;
            asm_q        <= '0;
            run_cnt      <= '0;
            shreg        <= '0;
            reg_idx      <= '0;
            tx_cnt       <= '0;
            marker       <= 1'b0;
        end else begin
            // The write strobe follows the cycle that completed the word.
            o_imem_we <= load_last_byte;
            if (load_last_byte) o_imem_wdata <= {asm_q, uart.i_rx_data};

            if ((state == S_LOAD_CNT) && uart.i_rx_valid) begin
                word_total  <= uart.i_rx_data;
                word_ctr    <= '0;
                byte_ctr    <= '0;
                o_imem_addr <= '0;
            end else if (o_imem_we) begin
                o_imem_addr <= o_imem_addr + IMEM_ADDR_W'(1);  // wraps naturally
            end

            if (load_byte) begin
                asm_q    <= {asm_q[15:0], uart.i_rx_data};
                byte_ctr <= byte_ctr + 2'd1;
                if (byte_ctr == 2'd3) word_ctr <= word_ctr + 9'd1;
            end

            if (state != S_RUN)        run_cnt <= '0;
            else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + RUN_CNT_W'(1);

            if (run_halt) begin
                reg_idx <= '0;
                marker  <= 1'b0;
            end else if (run_timeout) begin
                reg_idx <= '0;
                marker  <= 1'b1;
                shreg   <= {8'hEE, 24'h0};
            end

            if (state == S_DUMP_RD) begin
                shreg  <= i_reg_rdata;
                tx_cnt <= '0;
            end

            if (tx_fire) begin
                if (marker) begin
                    marker <= 1'b0;
                end else if (tx_cnt == 2'd3) begin
                    reg_idx <= reg_idx + 5'd1;  // 31 wraps back to 0 on exit
                end else begin
                    shreg  <= {shreg[23:0], 8'h00};
                    tx_cnt <= tx_cnt + 2'd1;
                end
            end
        end
    end

    assign uart.o_tx_data  = shreg[31:24];
    assign uart.o_tx_valid = (state == S_DUMP_TX);
    assign o_cpu_reset     = (state != S_RUN);
    assign o_reg_addr      = reg_idx;
    assign o_busy          = (state != S_IDLE);
    assign o_dbg_state     = state;

endmodule

// File: tb/tb_mips_debug_loader.sv
module tb_mips_debug_loader;

    localparam int AW = 2;
    localparam int T  = 50;

    logic          clk;
    logic          reset;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          cpu_halt;
    logic [4:0]    reg_addr;
    logic [31:0]   reg_rdata;
    logic          busy;
    logic [2:0]    dbg_state;

    mips_debug_loader_if bus();

    mips_debug_loader #(.IMEM_ADDR_W(AW), .RUN_TIMEOUT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart         (bus),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_cpu_reset  (cpu_reset),
        .i_cpu_halt   (cpu_halt),
        .o_reg_addr   (reg_addr),
        .i_reg_rdata  (reg_rdata),
        .o_busy       (busy),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   exp_q[$];       // expected imem write data
    logic [AW-1:0] exp_addr_q[$];  // expected imem write address
    logic [7:0]    tx_exp_q[$];    // expected transmitted bytes
    logic [31:0]   regs[32];       // register bank model
    logic [31:0]   prog[$];
    int            halt_after = 0; // 0 = core never halts
    int            low_cnt    = 0; // cycles the core was released
    int            stall_cnt  = 0;

    assign reg_rdata = regs[reg_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- core model ----------------
    initial begin
        cpu_halt = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && !cpu_reset) begin
                low_cnt++;
                if (halt_after != 0 && low_cnt >= halt_after) cpu_halt = 1'b1;
            end else begin
                cpu_halt = 1'b0;
            end
        end
    end

    // ---------------- TX ready driver ----------------
    initial begin
        bus.i_tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                bus.i_tx_ready = 1'b0;
                stall_cnt--;
            end else begin
                bus.i_tx_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            if (reset && imem_we) begin
                check("imem_write_expected", exp_q.size() != 0, 1);
                check("imem_cpu_held", cpu_reset, 1);
                if (exp_q.size() != 0) begin
                    a = exp_addr_q.pop_front();
                    check("imem_addr", imem_addr, a);
                    check("imem_wdata", imem_wdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic       prev_hold = 1'b0;
        logic [7:0] prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("tx_hold_valid", bus.o_tx_valid, 1);
                    check("tx_hold_data", bus.o_tx_data, prev_data);
                end
                if (bus.o_tx_valid && bus.i_tx_ready) begin
                    check("tx_byte_expected", tx_exp_q.size() != 0, 1);
                    if (tx_exp_q.size() != 0) check("tx_byte", bus.o_tx_data, tx_exp_q.pop_front());
                end
                prev_hold = bus.o_tx_valid && !bus.i_tx_ready;
                prev_data = bus.o_tx_data;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_reset"}, cpu_reset, 1);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_tx_valid"}, bus.o_tx_valid, 0);
        check({tag, "_tx_data"}, bus.o_tx_data, 0);
        check({tag, "_reg_addr"}, reg_addr, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals(tag);
        reset = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        tx_exp_q.delete();
        halt_after = 0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (!busy && exp_q.size() == 0 && tx_exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check({tag, "_idle"}, busy, 0);
        check({tag, "_imem_left"}, exp_q.size(), 0);
        check({tag, "_tx_left"}, tx_exp_q.size(), 0);
    endtask

    task automatic load_prog(input string tag);
        int n;
        n = prog.size();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(prog[i]);
            exp_addr_q.push_back(AW'(i % (1 << AW)));
        end
        send_byte(8'h4C);
        send_byte(8'(n));
        for (int i = 0; i < n; i++)
            for (int k = 3; k >= 0; k--) send_byte(8'(prog[i] >> (8 * k)));
        wait_idle(tag);
        check({tag, "_cpu_held"}, cpu_reset, 1);
    endtask

    task automatic rand_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
    endtask

    task automatic rand_regs();
        regs[0] = 32'h0;
        for (int r = 1; r < 32; r++) regs[r] = $urandom;
    endtask

    task automatic expect_dump(input int h);
        if (h == 0 || h > T) tx_exp_q.push_back(8'hEE);
        for (int r = 0; r < 32; r++)
            for (int k = 3; k >= 0; k--) tx_exp_q.push_back(8'(regs[r] >> (8 * k)));
    endtask

    task automatic run_dump(input string tag, input int h, input bit junk, input bit stall);
        int exp_low;
        exp_low = (h == 0 || h > T) ? T : h;
        expect_dump(h);
        low_cnt    = 0;
        halt_after = h;
        send_byte(8'h52);
        if (junk) send_byte(8'h4C);
        if (stall) begin
            for (int i = 0; i < 2000 && tx_exp_q.size() > 126; i++) begin
                @(posedge clk);
                #1;
            end
            stall_cnt = 5;
        end
        wait_idle(tag);
        check({tag, "_run_cycles"}, low_cnt, exp_low);
        check({tag, "_cpu_held"}, cpu_reset, 1);
        halt_after = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset          = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // two-word program
        prog.delete();
        prog.push_back(32'h20010005);
        prog.push_back(32'h20020064);
        load_prog("load2");

        // junk bytes in IDLE
        send_byte(8'h00);
        check("junk00_busy", busy, 0);
        send_byte(8'hFF);
        check("junkff_busy", busy, 0);

        // halt after 20 cycles, stall mid-word, RX dropped while running
        rand_regs();
        regs[1] = 32'd5;
        regs[2] = 32'd100;
        run_dump("run_halt20", 20, 1'b1, 1'b1);

        // timeout, then halt on the very timeout cycle
        rand_regs();
        run_dump("run_timeout", 0, 1'b0, 1'b0);
        rand_regs();
        run_dump("run_tie", T, 1'b0, 1'b0);

        // address wrap and empty load
        rand_prog(5);
        load_prog("load5_wrap");
        prog.delete();
        load_prog("load0");

        // randomized loads and runs
        for (int i = 0; i < 4; i++) begin
            rand_prog($urandom_range(1, 9));
            load_prog("load_rand");
            rand_regs();
            run_dump("run_rand", $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, T + 10),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        // reset in the middle of a word load
        send_byte(8'h4C);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset("rst_load");
        rand_prog(3);
        load_prog("load_after_rst");

        // reset in the middle of a dump
        rand_regs();
        expect_dump(5);
        low_cnt    = 0;
        halt_after = 5;
        send_byte(8'h52);
        for (int i = 0; i < 2000 && tx_exp_q.size() > 100; i++) begin
            @(posedge clk);
            #1;
        end
        check("rst_dump_reached", tx_exp_q.size() <= 100, 1);
        do_reset("rst_dump");
        send_byte(8'hFF);
        rand_prog(2);
        load_prog("load_after_dump_rst");
        rand_regs();
        run_dump("run_after_rst", 7, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
